// File: rtl/pc_btb_unit_if.sv
// rtl/pc_btb_unit_if.sv - fetch, redirect and branch-resolve signal bundle for pc_btb_unit
interface pc_btb_unit_if #(
  parameter int Psize = 5
);
  logic             stall;
  logic             mispredict;
  logic [Psize-1:0] recover_pc;
  logic             resolve_valid;
  logic [Psize-1:0] resolve_pc;
  logic             resolve_taken;
  logic [Psize-1:0] resolve_target;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_plus;
  logic             pred_taken;
  logic [Psize-1:0] pred_target;

  modport master (
    output stall, mispredict, recover_pc,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  pc, pc_plus, pred_taken, pred_target
  );

  modport slave (
    input  stall, mispredict, recover_pc,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output pc, pc_plus, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_btb_unit.sv
// rtl/pc_btb_unit.sv - program counter with direct-mapped branch target buffer
// Predicts at fetch from the current pc and learns from execute-stage branch resolution.
module pc_btb_unit #(
  parameter int Psize = 5,
  parameter int Bsize = 2,
  parameter int Csize = 2
) (
  input  logic           clk,
  input  logic           nreset,
  pc_btb_unit_if.slave   bus
);
  localparam int NENT  = 1 << Bsize;
  localparam int Tsize = Psize - Bsize;
  localparam logic [Csize-1:0] CTR_WT  = Csize'(1) << (Csize - 1);
  localparam logic [Csize-1:0] CTR_WNT = CTR_WT - Csize'(1);
  localparam logic [Csize-1:0] CTR_MAX = '1;

  logic [Psize-1:0] pc_q;
  logic             valid_q  [NENT];
  logic [Tsize-1:0] tag_q    [NENT];
  logic [Psize-1:0] target_q [NENT];
  logic [Csize-1:0] ctr_q    [NENT];

  logic [Bsize-1:0] f_idx;
  logic [Tsize-1:0] f_tag;
  logic [Bsize-1:0] r_idx;
  logic [Tsize-1:0] r_tag;
  logic             f_hit;
  logic             r_hit;
  logic             taken;
  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] next_fetch;

  assign f_idx  = pc_q[Bsize-1:0];
  assign f_tag  = pc_q[Psize-1:Bsize];
  assign r_idx  = bus.resolve_pc[Bsize-1:0];
  assign r_tag  = bus.resolve_pc[Psize-1:Bsize];
  assign pc_inc = pc_q + Psize'(1);

  // Prediction reads pre-update state, so a same-cycle resolve shows up next cycle.
  always_comb begin
    f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    taken      = f_hit && ctr_q[f_idx][Csize-1];
    next_fetch = taken ? target_q[f_idx] : pc_inc;
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus     = pc_inc;
  assign bus.pred_taken  = taken;
  assign bus.pred_target = next_fetch;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc_q <= '0;
      for (int i = 0; i < NENT; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      if (bus.mispredict) begin
        pc_q <= bus.recover_pc;
      end else if (!bus.stall) begin
        pc_q <= next_fetch;
      end

      // Training runs independently of stall and redirect.
      if (bus.resolve_valid) begin
        if (r_hit) begin
          if (bus.resolve_taken) begin
            target_q[r_idx] <= bus.resolve_target;
            if (ctr_q[r_idx] != CTR_MAX) begin
              ctr_q[r_idx] <= ctr_q[r_idx] + Csize'(1);
            end
          end else if (ctr_q[r_idx] != '0) begin
            ctr_q[r_idx] <= ctr_q[r_idx] - Csize'(1);
          end
        end else if (bus.resolve_taken) begin
          valid_q[r_idx]  <= 1'b1;
          tag_q[r_idx]    <= r_tag;
          target_q[r_idx] <= bus.resolve_target;
          ctr_q[r_idx]    <= CTR_WT;
        end
      end
    end
  end
endmodule

// File: doc/pc_btb_unit.md
Name: pc_btb_unit

Overview:
Parametrised next-generation program counter for the picoMIPS pipeline with an integrated direct-mapped branch target buffer (BTB).
- Each BTB entry holds an N-bit saturating direction counter.
- Predicts taken branches at fetch and redirects the PC to the stored target.
- Learns from branch resolution reported by the execute stage and recovers from mispredictions.
- Sits at the head of the fetch stage and drives the program-memory address.

Parameters:
Psize, 5, PC width in bits (program space 2^Psize words)
Bsize, 2, log2 of BTB entry count; must satisfy 1 <= Bsize < Psize
Csize, 2, direction counter width in bits; must be >= 1

Ports:
clk  input  1  clock, rising-edge active
nreset  input  1  asynchronous active-low reset
stall  input  1  hold PC (fetch stall)
mispredict  input  1  execute-stage redirect request
recover_pc  input  Psize  correct next PC on mispredict
resolve_valid  input  1  a branch resolved this cycle
resolve_pc  input  Psize  address of the resolved branch
resolve_taken  input  1  actual branch direction
resolve_target  input  Psize  actual branch target
pc  output  Psize  current fetch address
pc_plus  output  Psize  pc+1 modulo 2^Psize (combinational)
pred_taken  output  1  fetch-time prediction for pc (combinational)
pred_target  output  Psize  predicted next PC (combinational)

Behaviour:
- Single clock domain. Reset is asynchronous, active-low (nreset), acting immediately, including mid-operation.
- Reset values:
  - pc = 0.
  - Every entry: valid = 0, tag = 0, target = 0, counter = 2^(Csize-1)-1 (weakly not-taken; 0 when Csize = 1).
  - Consequence: pred_taken = 0 and pred_target = 1 after reset.
- BTB geometry:
  - 2^Bsize entries; each holds valid, tag[Psize-Bsize], target[Psize], ctr[Csize].
  - index = low Bsize bits of the address; tag = upper Psize-Bsize bits.
- Prediction (combinational, zero latency, from pc):
  - hit = valid[idx] & (tag[idx] == pc tag).
  - pred_taken = hit & ctr[idx] MSB.
  - pred_target = target[idx] if pred_taken, else pc_plus.
- Next-PC priority on rising clk, highest first:
  1. mispredict: pc <= recover_pc.
  2. stall: pc <= pc.
  3. otherwise: pc <= pred_target.
  - pc increments wrap 2^Psize-1 -> 0.
- BTB update on a rising clk with resolve_valid = 1. Updates occur regardless of stall and mispredict. Indexed by resolve_pc.
  - Hit, taken: ctr <= sat_inc(ctr); target <= resolve_target.
  - Hit, not taken: ctr <= sat_dec(ctr); target unchanged.
  - Miss, taken: allocate, overwriting any aliasing entry. valid <= 1, tag <= resolve_pc tag, target <= resolve_target, ctr <= 2^(Csize-1) (weakly taken).
  - Miss, not taken: no change.
  - Saturation: ctr never wraps; max 2^Csize-1, min 0.
- Same-cycle read/update: prediction in a cycle uses pre-update BTB state. The write becomes visible from the next cycle.
- resolve_valid = 0: BTB state unchanged.
- Interface rule: the unit never raises mispredict itself; the execute stage owns mispredict detection.

Test Plan:
Defaults for all scenarios: Psize=5, Bsize=2, Csize=2.
1. Reset, then free-run with no resolves -> pc steps 0,1,…,31,0 (wrap); pred_taken = 0 throughout; pc_plus = pc+1 mod 32.
2. Allocation: resolve_valid=1, resolve_pc=5, taken=1, target=20.
   -> Entry 1 becomes valid, tag=1, ctr=2.
   -> When pc=5: pred_taken=1, pred_target=20, next pc=20.
3. Counter saturation at pc=5:
   - Two not-taken resolves: ctr 2->1->0; pc=5 then goes to 6.
   - Four taken resolves: ctr 0->1->2->3->3; pred_taken=1 from ctr=2 onward.
4. Aliasing: with the pc=5 entry installed, fetch pc=9 (idx 1, tag 2) -> pred_taken=0.
   - Resolve pc=9 taken, target=3 -> entry replaced, ctr=2.
   - pc=5 then misses; pc=9 predicts target 3.
5. Priority: same cycle with mispredict=1, recover_pc=12, stall=1 and pred_taken=1 -> next pc=12.
   - Stall alone holds pc.
   - Resolve applied during stall is visible next cycle.
6. Reset mid-run: assert nreset low between clock edges with pc=17 and BTB populated.
   -> pc=0 immediately, no clk required.
   -> All entries invalid; pred_taken=0 at pc=5 after release.
